// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding used by the decoder and the execute unit,
// plus the execute FSM state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor shared by add, sub and slt.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_full;

    // Subtraction is A + ~B + 1; the carry-out then means A >= B unsigned.
    assign w_b      = sub ? ~b : b;
    assign w_full   = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};
    assign sum      = w_full[WIDTH-1:0];
    assign carry    = w_full[WIDTH];
    assign overflow = (a[WIDTH-1] == w_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute unit: single-cycle arithmetic/logic, one-bit-per-cycle
// shifter, valid/ready handshakes on both sides.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    alu_state_e       r_state, w_next;
    alu_op_e          r_op;
    alu_op_e          w_op;
    logic [4:0]       r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_neg, r_carry, r_ovf;

    logic             w_accept, w_step;
    logic [WIDTH-1:0] w_sum, w_res, w_shifted;
    logic             w_carry, w_ovf, w_arith;

    assign w_op    = alu_op_e'(ALUControl);
    assign w_arith = (w_op == ALU_ADD) || (w_op == ALU_SUB);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (A),
        .b        (B),
        .sub      (w_op != ALU_ADD),
        .sum      (w_sum),
        .carry    (w_carry),
        .overflow (w_ovf)
    );

    always_comb begin
        w_res = A;
        unique case (w_op)
            ALU_ADD, ALU_SUB: w_res = w_sum;
            ALU_AND:          w_res = A & B;
            ALU_OR:           w_res = A | B;
            ALU_SLT:          w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
            default:          w_res = A;
        endcase
    end

    always_comb begin
        w_shifted = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
        unique case (r_op)
            ALU_SLL: w_shifted = {r_result[WIDTH-2:0], 1'b0};
            ALU_SRL: w_shifted = {1'b0, r_result[WIDTH-1:1]};
            default: w_shifted = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = (is_shift(w_op) && (B[4:0] != 5'd0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                if (r_count == 5'd1) w_next = DONE;
            end
            DONE: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_result doubles as the shift working register; it only moves on acceptance or a shift step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= ALU_ADD;
            r_count  <= 5'd0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_op     <= w_op;
            r_count  <= B[4:0];
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_neg    <= w_res[WIDTH-1];
            r_carry  <= w_arith ? w_carry : 1'b0;
            r_ovf    <= w_arith ? w_ovf   : 1'b0;
        end else if (w_step) begin
            r_count  <= r_count - 5'd1;
            r_result <= w_shifted;
            r_zero   <= (w_shifted == '0);
            r_neg    <= w_shifted[WIDTH-1];
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign Result    = r_result;
    assign Zero      = r_zero;
    assign Negative  = r_neg;
    assign Carry     = r_carry;
    assign Overflow  = r_ovf;

endmodule
